// File: rtl/alu_execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_execute_stage
// Description : Single-issue execute stage with an 8-entry register file.
//               Handles NOP/ADD/SUB/AND/OR/XOR/SLL in one cycle and MUL as an
//               iterative shift-add that takes WIDTH cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_execute_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [2:0]       rs1,
    input  logic [2:0]       rs2,
    input  logic [2:0]       rd,
    input  logic             init_we,
    input  logic [2:0]       init_addr,
    input  logic [WIDTH-1:0] init_data,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       result_rd,
    output logic             zero_flag,
    output logic             carry_flag
);

    localparam int              c_CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST    = c_CW'(WIDTH - 1);

    localparam logic [0:0]      c_ST_IDLE = 1'b0;
    localparam logic [0:0]      c_ST_MUL  = 1'b1;

    localparam logic [2:0]      c_OP_NOP  = 3'd0;
    localparam logic [2:0]      c_OP_ADD  = 3'd1;
    localparam logic [2:0]      c_OP_SUB  = 3'd2;
    localparam logic [2:0]      c_OP_AND  = 3'd3;
    localparam logic [2:0]      c_OP_OR   = 3'd4;
    localparam logic [2:0]      c_OP_XOR  = 3'd5;
    localparam logic [2:0]      c_OP_SLL  = 3'd6;
    localparam logic [2:0]      c_OP_MUL  = 3'd7;

    logic [WIDTH-1:0]   r_regs [8];
    logic [0:0]         r_state;
    logic [0:0]         w_state_next;

    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic               w_accept;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_shl;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_carry;

    // Multiplier datapath: multiplicand shifts left, multiplier shifts right
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [c_CW-1:0]    r_count;
    logic [2:0]         r_mul_rd;
    logic               w_mul_done;

    assign in_ready   = (r_state == c_ST_IDLE) && !reset;
    assign w_accept   = in_valid && in_ready;
    assign w_a        = r_regs[rs1];
    assign w_b        = r_regs[rs2];
    assign dbg_data   = r_regs[dbg_addr];

    assign w_sum      = {1'b0, w_a} + {1'b0, w_b};
    assign w_shl      = {{WIDTH{1'b0}}, w_a} << w_b[2:0];
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_done = (r_state == c_ST_MUL) && (r_count == c_LAST);

    // Single-cycle ALU result and carry for the op being accepted
    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        case (opcode)
            c_OP_ADD: begin
                w_alu_res   = w_sum[WIDTH-1:0];
                w_alu_carry = w_sum[WIDTH];
            end
            c_OP_SUB: begin
                w_alu_res   = w_a - w_b;
                w_alu_carry = (w_a < w_b);
            end
            c_OP_AND: w_alu_res = w_a & w_b;
            c_OP_OR:  w_alu_res = w_a | w_b;
            c_OP_XOR: w_alu_res = w_a ^ w_b;
            c_OP_SLL: begin
                w_alu_res   = w_shl[WIDTH-1:0];
                w_alu_carry = |w_shl[2*WIDTH-1:WIDTH];
            end
            default: begin
                w_alu_res   = '0;
                w_alu_carry = 1'b0;
            end
        endcase
    end

    // Next-state: MUL accepted from IDLE enters MUL; last iteration returns
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept && (opcode == c_OP_MUL)) w_state_next = c_ST_MUL;
            c_ST_MUL:  if (r_count == c_LAST)                w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Register file, multiplier iteration and result/flag outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
            out_valid  <= 1'b0;
            result     <= '0;
            result_rd  <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_count    <= '0;
            r_mul_rd   <= '0;
        end else begin
            out_valid <= 1'b0;
            // Preload first so a same-index ALU writeback below overrides it
            if (init_we && in_ready) r_regs[init_addr] <= init_data;
            if (w_accept) begin
                if (opcode == c_OP_MUL) begin
                    r_mcand  <= {{WIDTH{1'b0}}, w_a};
                    r_mplier <= w_b;
                    r_mul_rd <= rd;
                    r_acc    <= '0;
                    r_count  <= '0;
                end else if (opcode != c_OP_NOP) begin
                    r_regs[rd] <= w_alu_res;
                    result     <= w_alu_res;
                    result_rd  <= rd;
                    zero_flag  <= (w_alu_res == '0);
                    carry_flag <= w_alu_carry;
                    out_valid  <= 1'b1;
                end
            end
            if (r_state == c_ST_MUL) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + c_CW'(1);
                if (w_mul_done) begin
                    r_regs[r_mul_rd] <= w_acc_next[WIDTH-1:0];
                    result           <= w_acc_next[WIDTH-1:0];
                    result_rd        <= r_mul_rd;
                    zero_flag        <= (w_acc_next[WIDTH-1:0] == '0);
                    carry_flag       <= |w_acc_next[2*WIDTH-1:WIDTH];
                    out_valid        <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_execute_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_alu_execute_stage
// Description : Directed plus randomized bench for alu_execute_stage with a
//               behavioural register-file / arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_execute_stage;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   opcode, rs1, rs2, rd;
    logic         init_we;
    logic [2:0]   init_addr;
    logic [W-1:0] init_data;
    logic [2:0]   dbg_addr;
    logic [W-1:0] dbg_data;
    logic         out_valid;
    logic [W-1:0] result;
    logic [2:0]   result_rd;
    logic         zero_flag, carry_flag;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int m_regs [8];
    int m_res, m_rd;
    bit m_zero, m_carry;
    int e_op, e_res, e_rd;
    bit e_carry;

    alu_execute_stage #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .out_valid(out_valid),
        .result(result), .result_rd(result_rd),
        .zero_flag(zero_flag), .carry_flag(carry_flag)
    );

    always #10 clk = ~clk;

    initial begin
        #4000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Arithmetic meaning of each op, computed on plain integers
    function automatic void ref_alu(input int op, input int a, input int b,
                                    output int res, output bit c);
        int full;
        res = 0; c = 1'b0;
        case (op)
            1: begin full = a + b;          res = full & MASK; c = (full > MASK); end
            2: begin res = (a - b) & MASK;  c = (a < b); end
            3: res = a & b;
            4: res = a | b;
            5: res = a ^ b;
            6: begin full = a << (b % 8);   res = full & MASK; c = ((full >> W) != 0); end
            7: begin full = a * b;          res = full & MASK; c = ((full >> W) != 0); end
            default: res = 0;
        endcase
    endfunction

    task automatic check_dbg(input int a, input string tag);
        logic [2:0] idx;
        idx = a[2:0];
        dbg_addr = idx;
        #1;
        chk(tag, dbg_data, m_regs[a]);
    endtask

    task automatic preload(input int a, input int d);
        logic [2:0]   ia;
        logic [W-1:0] id;
        ia = a[2:0]; id = d[W-1:0];
        init_we = 1'b1; init_addr = ia; init_data = id;
        step();
        init_we = 1'b0;
        m_regs[a] = d & MASK;
    endtask

    task automatic launch(input int op, input int s1, input int s2, input int d,
                          input bit keep, input bit with_init, input int ia, input int idat);
        logic [2:0] v_op, v_s1, v_s2, v_d, v_ia;
        logic [W-1:0] v_id;
        v_op = op[2:0]; v_s1 = s1[2:0]; v_s2 = s2[2:0]; v_d = d[2:0];
        v_ia = ia[2:0]; v_id = idat[W-1:0];
        opcode = v_op; rs1 = v_s1; rs2 = v_s2; rd = v_d; in_valid = 1'b1;
        if (with_init) begin
            init_we = 1'b1; init_addr = v_ia; init_data = v_id;
        end
        chk("in_ready_at_accept", in_ready, 1);
        e_op = op; e_rd = d;
        ref_alu(op, m_regs[s1], m_regs[s2], e_res, e_carry);
        step();
        if (!keep) in_valid = 1'b0;
        init_we = 1'b0;
        if (with_init) m_regs[ia] = idat & MASK;
    endtask

    task automatic wait_mul(input bit inject);
        for (int i = 0; i < W; i++) begin
            chk("mul_busy_ready", in_ready, 0);
            chk("mul_busy_nopulse", out_valid, 0);
            if (inject && i == 2) begin
                init_we = 1'b1; init_addr = 3'd5; init_data = 8'hA5;
            end
            step();
            init_we = 1'b0;
        end
        in_valid = 1'b0;
        chk("mul_done_ready", in_ready, 1);
    endtask

    task automatic finish_op();
        if (e_op == 0) begin
            chk("nop_no_pulse", out_valid, 0);
            chk("nop_result_held", result, m_res);
            chk("nop_rd_held", result_rd, m_rd);
            chk("nop_zero_held", zero_flag, m_zero);
            chk("nop_carry_held", carry_flag, m_carry);
        end else begin
            chk("out_valid", out_valid, 1);
            chk("result", result, e_res);
            chk("result_rd", result_rd, e_rd);
            chk("zero_flag", zero_flag, (e_res == 0));
            chk("carry_flag", carry_flag, e_carry);
            m_regs[e_rd] = e_res;
            m_res = e_res; m_rd = e_rd; m_zero = (e_res == 0); m_carry = e_carry;
            check_dbg(e_rd, "dbg_writeback");
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_res = 0; m_rd = 0; m_zero = 1'b0; m_carry = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; init_we = 1'b0;
        opcode = '0; rs1 = '0; rs2 = '0; rd = '0;
        init_addr = '0; init_data = '0; dbg_addr = '0;
        model_reset();

        // Reset state
        repeat (3) step();
        chk("ready_in_reset", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_result_rd", result_rd, 0);
        chk("reset_zero", zero_flag, 0);
        chk("reset_carry", carry_flag, 0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", in_ready, 1);
        for (int i = 0; i < 8; i++) check_dbg(i, "reset_reg");

        // ADD without carry
        preload(1, 8'h7F); preload(2, 8'h01);
        launch(1, 1, 2, 3, 0, 0, 0, 0); finish_op();
        chk("tp_add_7f_1", result, 8'h80);

        // ADD wrapping to zero, then SUB with borrow
        preload(1, 8'hFF);
        launch(1, 1, 2, 4, 0, 0, 0, 0); finish_op();
        chk("tp_add_wrap_zero", zero_flag, 1);
        chk("tp_add_wrap_carry", carry_flag, 1);
        launch(2, 2, 1, 5, 0, 0, 0, 0); finish_op();
        chk("tp_sub_borrow_res", result, 8'h02);
        chk("tp_sub_borrow_c", carry_flag, 1);

        // Back-to-back read-after-write
        preload(1, 8'h05); preload(2, 8'h03);
        launch(1, 1, 2, 3, 0, 0, 0, 0); finish_op();
        launch(5, 3, 1, 4, 0, 0, 0, 0); finish_op();
        chk("tp_raw_xor", result, 8'h0D);

        // Multiply 0x0C x 0x0B
        preload(1, 8'h0C); preload(2, 8'h0B);
        launch(7, 1, 2, 6, 0, 0, 0, 0); wait_mul(0); finish_op();
        chk("tp_mul_res", result, 8'h84);
        chk("tp_mul_carry", carry_flag, 0);

        // Multiply overflowing to zero with in_valid held high throughout
        preload(1, 8'h10); preload(2, 8'h10);
        launch(7, 1, 2, 7, 1, 0, 0, 0); wait_mul(0); finish_op();
        chk("tp_mul_ovf_zero", zero_flag, 1);
        chk("tp_mul_ovf_carry", carry_flag, 1);
        step();
        chk("held_valid_no_extra_pulse", out_valid, 0);
        chk("held_valid_no_extra_accept", in_ready, 1);

        // Preload while busy is ignored
        preload(5, 8'h11);
        launch(7, 1, 2, 6, 0, 0, 0, 0); wait_mul(1); finish_op();
        check_dbg(5, "init_ignored_busy");

        // NOP holds everything
        launch(0, 1, 2, 3, 0, 0, 0, 0); finish_op();

        // SLL shifting out a one
        preload(1, 8'h81); preload(2, 8'h01);
        launch(6, 1, 2, 3, 0, 0, 0, 0); finish_op();
        chk("tp_sll_res", result, 8'h02);
        chk("tp_sll_carry", carry_flag, 1);

        // Randomized back-to-back traffic with occasional concurrent preloads
        for (int n = 0; n < 80; n++) begin
            int op, s1, s2, d, ia, idat;
            bit wi;
            op   = int'($urandom_range(0, 7));
            s1   = int'($urandom_range(0, 7));
            s2   = int'($urandom_range(0, 7));
            d    = int'($urandom_range(0, 7));
            wi   = ($urandom_range(0, 3) == 0);
            ia   = int'($urandom_range(0, 7));
            idat = int'($urandom_range(0, MASK));
            if ($urandom_range(0, 4) == 0) preload(int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)));
            launch(op, s1, s2, d, 0, wi, ia, idat);
            if (op == 7) wait_mul(0);
            finish_op();
            if (wi) check_dbg(ia, "rand_init_or_wb");
        end

        // Reset during the fourth multiply iteration aborts it
        preload(1, 8'h0C); preload(2, 8'h0B);
        launch(7, 1, 2, 6, 0, 0, 0, 0);
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("abort_no_pulse", out_valid, 0);
        chk("abort_ready_in_reset", in_ready, 0);
        step();
        reset = 1'b0;
        model_reset();
        #1;
        chk("abort_ready_after", in_ready, 1);
        chk("abort_result", result, 0);
        chk("abort_carry", carry_flag, 0);
        for (int i = 0; i < 8; i++) check_dbg(i, "abort_reg");
        step();
        chk("abort_no_late_pulse", out_valid, 0);
        check_dbg(6, "abort_no_late_wb");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
